// File: rtl/sprite_motion_ctrl.sv
// sprite_motion_ctrl
// Tick-driven movement engine for one sprite on a tile map. On every
// movement tick with a requested direction it looks up both leading-edge
// corners of the candidate bounding box in the map ROM, then commits or
// rejects the step and advances the walk animation frame.
//
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   enable           stage active; low holds position and aborts a lookup
//   restart          synchronous pulse, reloads the start position
//   dir_valid, dir   requested direction (0 up, 1 left, 2 down, 3 right)
//   map_rd           map lookup strobe, with map_row / map_col address
//   map_blocked      wall bit, valid the cycle after map_rd
//   pos_x, pos_y     sprite top-left pixel position
//   anim_state       animation group base (0/3/6/9) plus frame (0..2)
//   moving           last step attempt was accepted
//   step_done        one-cycle pulse when a step attempt resolves
module sprite_motion_ctrl #(
    parameter int X_W         = 9,
    parameter int Y_W         = 9,
    parameter int ORIGIN_X    = 60,
    parameter int ORIGIN_Y    = 30,
    parameter int TILE_SHIFT  = 3,
    parameter int MAP_COLS    = 32,
    parameter int MAP_ROWS    = 32,
    parameter int SPR_W       = 8,
    parameter int SPR_H       = 8,
    parameter int SPEED       = 1,
    parameter int TICK_CYCLES = 16,
    parameter int START_X     = 64,
    parameter int START_Y     = 130
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        enable,
    input  logic                        restart,
    input  logic                        dir_valid,
    input  logic [1:0]                  dir,
    output logic                        map_rd,
    output logic [$clog2(MAP_ROWS)-1:0] map_row,
    output logic [$clog2(MAP_COLS)-1:0] map_col,
    input  logic                        map_blocked,
    output logic [X_W-1:0]              pos_x,
    output logic [Y_W-1:0]              pos_y,
    output logic [3:0]                  anim_state,
    output logic                        moving,
    output logic                        step_done
);

    localparam int ROW_W = $clog2(MAP_ROWS);
    localparam int COL_W = $clog2(MAP_COLS);
    localparam int CNT_W = $clog2(TICK_CYCLES);
    localparam int XW1   = X_W + 1;
    localparam int YW1   = Y_W + 1;

    // Coordinates are handled one bit wider than the position so that a
    // step below zero wraps far above the map and reads as out of bounds.
    localparam logic [X_W:0]       X_LO      = XW1'(ORIGIN_X);
    localparam logic [X_W:0]       X_HI      = XW1'(ORIGIN_X + (MAP_COLS << TILE_SHIFT));
    localparam logic [Y_W:0]       Y_LO      = YW1'(ORIGIN_Y);
    localparam logic [Y_W:0]       Y_HI      = YW1'(ORIGIN_Y + (MAP_ROWS << TILE_SHIFT));
    localparam logic [X_W:0]       SPR_DX    = XW1'(SPR_W - 1);
    localparam logic [Y_W:0]       SPR_DY    = YW1'(SPR_H - 1);
    localparam logic [X_W:0]       STEP_X    = XW1'(SPEED);
    localparam logic [Y_W:0]       STEP_Y    = YW1'(SPEED);
    localparam logic [X_W-1:0]     START_XV  = X_W'(START_X);
    localparam logic [Y_W-1:0]     START_YV  = Y_W'(START_Y);
    localparam logic [CNT_W-1:0]   TICK_LAST = CNT_W'(TICK_CYCLES - 1);

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_LEFT  = 2'd1;
    localparam logic [1:0] DIR_DOWN  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    typedef enum logic [1:0] {IDLE, LOOK_A, LOOK_B, DECIDE} state_t;

    // x of the first (second = 0) or second leading-edge corner.
    function automatic logic [X_W:0] corner_x(input logic [1:0] d, input logic [X_W:0] cx,
                                              input logic second);
        logic [X_W:0] r;
        case (d)
            DIR_LEFT:  r = cx;
            DIR_RIGHT: r = cx + SPR_DX;
            default:   r = second ? cx + SPR_DX : cx;
        endcase
        return r;
    endfunction

    // y of the first (second = 0) or second leading-edge corner.
    function automatic logic [Y_W:0] corner_y(input logic [1:0] d, input logic [Y_W:0] cy,
                                              input logic second);
        logic [Y_W:0] r;
        case (d)
            DIR_UP:   r = cy;
            DIR_DOWN: r = cy + SPR_DY;
            default:  r = second ? cy + SPR_DY : cy;
        endcase
        return r;
    endfunction

    function automatic logic [3:0] dir_base(input logic [1:0] d);
        logic [3:0] r;
        case (d)
            DIR_UP:   r = 4'd0;
            DIR_LEFT: r = 4'd6;
            DIR_DOWN: r = 4'd9;
            default:  r = 4'd3;
        endcase
        return r;
    endfunction

    function automatic logic corner_oob(input logic [X_W:0] px, input logic [Y_W:0] py);
        return (px < X_LO) || (px >= X_HI) || (py < Y_LO) || (py >= Y_HI);
    endfunction

    state_t           state_r;
    logic [CNT_W-1:0] tick_cnt_r;
    logic [1:0]       dir_r;
    logic [X_W:0]     cand_x_r;
    logic [Y_W:0]     cand_y_r;
    logic             a_oob_r;
    logic             a_blk_r;

    logic             tick_s;
    logic [X_W:0]     cand_x_s;
    logic [Y_W:0]     cand_y_s;
    logic [X_W:0]     a_px_s;
    logic [Y_W:0]     a_py_s;
    logic [X_W:0]     b_px_s;
    logic [Y_W:0]     b_py_s;
    logic             a_oob_s;
    logic             b_oob_s;
    logic [ROW_W-1:0] a_row_s;
    logic [COL_W-1:0] a_col_s;
    logic [ROW_W-1:0] b_row_s;
    logic [COL_W-1:0] b_col_s;
    logic [3:0]       frame_s;

    assign tick_s = (tick_cnt_r == TICK_LAST);

    // Corner A comes from the live candidate (used in the tick cycle),
    // corner B from the latched candidate (used in LOOK_A and DECIDE).
    assign a_px_s  = corner_x(dir, cand_x_s, 1'b0);
    assign a_py_s  = corner_y(dir, cand_y_s, 1'b0);
    assign b_px_s  = corner_x(dir_r, cand_x_r, 1'b1);
    assign b_py_s  = corner_y(dir_r, cand_y_r, 1'b1);
    assign a_oob_s = corner_oob(a_px_s, a_py_s);
    assign b_oob_s = corner_oob(b_px_s, b_py_s);
    assign a_col_s = COL_W'((a_px_s - X_LO) >> TILE_SHIFT);
    assign a_row_s = ROW_W'((a_py_s - Y_LO) >> TILE_SHIFT);
    assign b_col_s = COL_W'((b_px_s - X_LO) >> TILE_SHIFT);
    assign b_row_s = ROW_W'((b_py_s - Y_LO) >> TILE_SHIFT);

    // Walk frame within the current animation group (0 idle, 1/2 walking).
    assign frame_s = anim_state % 4'd3;

    // Candidate position one step along the requested direction.
    always_comb begin
        cand_x_s = {1'b0, pos_x};
        cand_y_s = {1'b0, pos_y};
        case (dir)
            DIR_UP:    cand_y_s = {1'b0, pos_y} - STEP_Y;
            DIR_LEFT:  cand_x_s = {1'b0, pos_x} - STEP_X;
            DIR_DOWN:  cand_y_s = {1'b0, pos_y} + STEP_Y;
            DIR_RIGHT: cand_x_s = {1'b0, pos_x} + STEP_X;
            default:   cand_x_s = {1'b0, pos_x};
        endcase
    end

    // Free-running movement tick counter; restart deliberately leaves it alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_cnt_r <= '0;
        end else if (tick_s) begin
            tick_cnt_r <= '0;
        end else begin
            tick_cnt_r <= tick_cnt_r + CNT_W'(1);
        end
    end

    // Step FSM: corner lookups, commit/reject and animation, all registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            pos_x      <= START_XV;
            pos_y      <= START_YV;
            anim_state <= 4'd3;
            moving     <= 1'b0;
            step_done  <= 1'b0;
            map_rd     <= 1'b0;
            map_row    <= '0;
            map_col    <= '0;
            dir_r      <= 2'd0;
            cand_x_r   <= '0;
            cand_y_r   <= '0;
            a_oob_r    <= 1'b0;
            a_blk_r    <= 1'b0;
        end else if (restart) begin
            state_r    <= IDLE;
            pos_x      <= START_XV;
            pos_y      <= START_YV;
            anim_state <= 4'd3;
            moving     <= 1'b0;
            step_done  <= 1'b0;
            map_rd     <= 1'b0;
        end else begin
            step_done <= 1'b0;
            case (state_r)
                IDLE: begin
                    map_rd <= 1'b0;
                    if (tick_s && enable) begin
                        if (dir_valid) begin
                            dir_r    <= dir;
                            cand_x_r <= cand_x_s;
                            cand_y_r <= cand_y_s;
                            a_oob_r  <= a_oob_s;
                            // An out-of-map corner is never looked up.
                            map_rd   <= ~a_oob_s;
                            map_row  <= a_row_s;
                            map_col  <= a_col_s;
                            state_r  <= LOOK_A;
                        end else begin
                            anim_state <= anim_state - frame_s;
                        end
                    end
                end
                LOOK_A: begin
                    if (!enable) begin
                        map_rd  <= 1'b0;
                        state_r <= IDLE;
                    end else begin
                        map_rd  <= ~b_oob_s;
                        map_row <= b_row_s;
                        map_col <= b_col_s;
                        state_r <= LOOK_B;
                    end
                end
                LOOK_B: begin
                    map_rd <= 1'b0;
                    if (!enable) begin
                        state_r <= IDLE;
                    end else begin
                        a_blk_r <= a_oob_r | map_blocked;
                        state_r <= DECIDE;
                    end
                end
                DECIDE: begin
                    map_rd  <= 1'b0;
                    state_r <= IDLE;
                    if (enable) begin
                        if (!(a_blk_r || b_oob_s || map_blocked)) begin
                            pos_x  <= cand_x_r[X_W-1:0];
                            pos_y  <= cand_y_r[Y_W-1:0];
                            moving <= 1'b1;
                        end else begin
                            moving <= 1'b0;
                        end
                        // The walk frame advances even when the step is rejected.
                        anim_state <= dir_base(dir_r) + ((frame_s == 4'd1) ? 4'd2 : 4'd1);
                        step_done  <= 1'b1;
                    end
                end
                default: begin
                    map_rd  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Self-checking bench for sprite_motion_ctrl (default parameters).
// Each 16-cycle window applies one set of inputs around exactly one tick; a
// reference model predicts the map lookups and the step outcome and queues
// them, and monitors pop and compare whenever the DUT strobes map_rd or
// step_done.
module tb_sprite_motion_ctrl;

    localparam int OX = 60;
    localparam int OY = 30;
    localparam int MAP_PIX = 32 * 8;
    localparam int SX = 64;
    localparam int SY = 130;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       restart;
    logic       dir_valid;
    logic [1:0] dir;
    logic       map_rd;
    logic [4:0] map_row;
    logic [4:0] map_col;
    logic       map_blocked = 1'b0;
    logic [8:0] pos_x;
    logic [8:0] pos_y;
    logic [3:0] anim_state;
    logic       moving;
    logic       step_done;

    sprite_motion_ctrl dut (
        .clk(clk), .rst(rst), .enable(enable), .restart(restart),
        .dir_valid(dir_valid), .dir(dir), .map_rd(map_rd), .map_row(map_row),
        .map_col(map_col), .map_blocked(map_blocked), .pos_x(pos_x), .pos_y(pos_y),
        .anim_state(anim_state), .moving(moving), .step_done(step_done)
    );

    always #5 clk = ~clk;

    int unsigned pcnt = 0;
    always @(posedge clk) pcnt <= pcnt + 1;

    // Map ROM: one-cycle read latency; junk on non-read cycles.
    logic walls [0:31][0:31];
    always @(posedge clk) map_blocked <= map_rd ? walls[map_row][map_col] : 1'($urandom);

    typedef struct { int x; int y; int anim; int mov; int at; } step_t;
    typedef struct { int row; int col; int at; } req_t;
    step_t exp_q[$];
    req_t  req_q[$];

    int n_vec = 0;
    int n_bad = 0;
    int mx, my, manim, mmov;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: compare DUT lookups and step results against the queued model.
    always @(negedge clk) begin
        step_t e;
        req_t  r;
        if (!rst) begin
            if (map_rd) begin
                if (req_q.size() == 0) begin
                    chk("unexpected_map_rd", 1, 0);
                end else begin
                    r = req_q.pop_front();
                    chk("map_rd_time", int'(pcnt), r.at);
                    chk("map_row", int'(map_row), r.row);
                    chk("map_col", int'(map_col), r.col);
                end
            end
            if (step_done) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_step_done", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("step_done_time", int'(pcnt), e.at);
                    chk("step_pos_x", int'(pos_x), e.x);
                    chk("step_pos_y", int'(pos_y), e.y);
                    chk("step_anim", int'(anim_state), e.anim);
                    chk("step_moving", int'(moving), e.mov);
                end
            end
        end
    end

    // Model one corner: out of map is blocked without a lookup.
    task automatic model_corner(input int px, input int py, input int at, inout bit blk);
        req_t r;
        if (px < OX || px >= OX + MAP_PIX || py < OY || py >= OY + MAP_PIX) begin
            blk = 1'b1;
        end else begin
            r.row = (py - OY) / 8;
            r.col = (px - OX) / 8;
            r.at  = at;
            req_q.push_back(r);
            if (walls[r.row][r.col]) blk = 1'b1;
        end
    endtask

    // One tick window. kind: 0 none, 1 restart in LOOK_B, 2 enable drop in LOOK_B.
    task automatic window(input bit en, input bit dv, input bit [1:0] d, input int kind);
        int s, cx, cy, l, rgt, top, bot, base, fr;
        bit blk;
        step_t e;
        s = int'(pcnt);
        enable = en; dir_valid = dv; dir = d;
        if (en && dv) begin
            cx = mx + (d == 2'd3 ? 1 : (d == 2'd1 ? -1 : 0));
            cy = my + (d == 2'd2 ? 1 : (d == 2'd0 ? -1 : 0));
            l = cx; rgt = cx + 7; top = cy; bot = cy + 7;
            blk = 1'b0;
            case (d)
                2'd0: begin model_corner(l, top, s + 8, blk);   model_corner(rgt, top, s + 9, blk); end
                2'd1: begin model_corner(l, top, s + 8, blk);   model_corner(l, bot, s + 9, blk);   end
                2'd2: begin model_corner(l, bot, s + 8, blk);   model_corner(rgt, bot, s + 9, blk); end
                default: begin model_corner(rgt, top, s + 8, blk); model_corner(rgt, bot, s + 9, blk); end
            endcase
            if (kind == 0) begin
                base = (d == 2'd0) ? 0 : (d == 2'd1) ? 6 : (d == 2'd2) ? 9 : 3;
                fr = manim % 3;
                manim = base + ((fr == 1) ? 2 : 1);
                if (!blk) begin mx = cx; my = cy; end
                mmov = blk ? 0 : 1;
                e.x = mx; e.y = my; e.anim = manim; e.mov = mmov; e.at = s + 11;
                exp_q.push_back(e);
            end
        end else if (en) begin
            manim = (manim / 3) * 3;
        end
        if (kind == 1) begin mx = SX; my = SY; manim = 3; mmov = 0; end
        repeat (9) @(posedge clk);
        @(negedge clk);
        // Inputs after the tick must be ignored.
        dir = 2'($urandom); dir_valid = 1'($urandom);
        if (kind == 1) restart = 1'b1;
        if (kind == 2) enable = 1'b0;
        @(posedge clk);
        @(negedge clk);
        restart = 1'b0; enable = en;
        if (kind == 1) begin
            chk("restart_pos_x", int'(pos_x), SX);
            chk("restart_pos_y", int'(pos_y), SY);
            chk("restart_anim", int'(anim_state), 3);
            chk("restart_map_rd", int'(map_rd), 0);
        end
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk("win_pos_x", int'(pos_x), mx);
        chk("win_pos_y", int'(pos_y), my);
        chk("win_anim", int'(anim_state), manim);
        chk("win_moving", int'(moving), mmov);
        if (req_q.size() != 0) begin
            chk("missing_map_rd", req_q.size(), 0);
            req_q.delete();
        end
    endtask

    initial begin
        for (int r = 0; r < 32; r++)
            for (int c = 0; c < 32; c++)
                walls[r][c] = 1'b0;
        rst = 1'b1; enable = 1'b0; restart = 1'b0; dir_valid = 1'b0; dir = 2'd0;
        mx = SX; my = SY; manim = 3; mmov = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_pos_x", int'(pos_x), SX);
        chk("reset_pos_y", int'(pos_y), SY);
        chk("reset_anim", int'(anim_state), 3);
        chk("reset_map_rd", int'(map_rd), 0);
        chk("reset_moving", int'(moving), 0);
        chk("reset_step_done", int'(step_done), 0);
        chk("reset_map_row", int'(map_row), 0);
        chk("reset_map_col", int'(map_col), 0);
        rst = 1'b0;
        repeat (8) @(posedge clk);
        @(negedge clk);

        // Idle run: nothing moves, no step_done (monitor flags any).
        window(1'b1, 1'b0, 2'd0, 0);
        window(1'b0, 1'b1, 2'd3, 0);
        // Open map, right three ticks.
        for (int i = 0; i < 3; i++) window(1'b1, 1'b1, 2'd3, 0);
        chk("right3_pos_x", int'(pos_x), 67);
        chk("right3_anim", int'(anim_state), 4);
        // Drop dir_valid: animation back to idle base.
        window(1'b1, 1'b0, 2'd3, 0);
        chk("idle_anim", int'(anim_state), 3);
        chk("idle_pos_x", int'(pos_x), 67);
        // Left to the map edge.
        window(1'b1, 1'b0, 2'd0, 1);
        for (int i = 0; i < 5; i++) window(1'b1, 1'b1, 2'd1, 0);
        chk("left_edge_pos_x", int'(pos_x), 60);
        chk("left_edge_moving", int'(moving), 0);
        // Wall at column 2, rows 12-13.
        window(1'b1, 1'b0, 2'd0, 1);
        walls[12][2] = 1'b1; walls[13][2] = 1'b1;
        for (int i = 0; i < 5; i++) window(1'b1, 1'b1, 2'd3, 0);
        chk("wall_pos_x", int'(pos_x), 68);
        chk("wall_moving", int'(moving), 0);
        // Restart in LOOK_B after reaching x=66.
        window(1'b1, 1'b0, 2'd0, 1);
        for (int i = 0; i < 2; i++) window(1'b1, 1'b1, 2'd3, 0);
        window(1'b1, 1'b1, 2'd3, 1);
        window(1'b1, 1'b1, 2'd0, 2);

        // Random walls and traffic.
        for (int r = 0; r < 32; r++)
            for (int c = 0; c < 32; c++)
                walls[r][c] = ($urandom_range(0, 9) == 0);
        for (int i = 0; i < 150; i++) begin
            int k;
            k = $urandom_range(0, 15);
            window($urandom_range(0, 9) != 0, $urandom_range(0, 4) != 0, 2'($urandom),
                   (k == 0) ? 1 : ((k == 1) ? 2 : 0));
        end

        chk("leftover_steps", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
